axi_mem_slave: RTL and testbench



---
 rtl/axi_mem_pkg.sv | 29 ++
 rtl/axi_mem_addr_gen.sv | 39 +++
 rtl/axi_mem_slave.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared encodings for the AXI4 memory responder: burst types, response
// codes and the read/write FSM state sets.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Only these burst lengths are legal for WRAP; anything else falls back to INCR.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Combinational next-beat address for one AXI burst channel.
// FIXED holds the address, INCR/reserved add 1<<size, WRAP wraps inside the
// (len+1)<<size aligned window.
module axi_mem_addr_gen
  import axi_mem_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] incr_s;
  logic [31:0] sum_s;
  logic [31:0] mask_s;

  assign incr_s = 32'd1 << size;
  assign sum_s  = addr + incr_s;
  assign mask_s = ((32'(len) + 32'd1) << size) - 32'd1;

  // Pick the next address according to the burst type.
  always_comb begin
    next_addr = sum_s;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = sum_s;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_addr = (addr & ~mask_s) | (sum_s & mask_s);
        end else begin
          next_addr = sum_s;
        end
      end
      default:     next_addr = sum_s;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by an on-chip word array. Independent read and write
// channels, one outstanding burst each. Optional feature macro:
// AXI_MEM_DECERR_EN -- out-of-window beats answer DECERR instead of aliasing.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int          ID_WIDTH  = 6,
  parameter int          MEM_AW    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                cpu_clk,
  input  logic                cpu_reset_n,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
    return MEM_AW'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- write channel ----------------
  wr_state_e           wr_state_r, wr_state_s;
  logic [ID_WIDTH-1:0] wr_id_r;
  logic [31:0]         wr_addr_r, wr_next_s;
  logic [7:0]          wr_len_r, wr_cnt_r;
  logic [2:0]          wr_size_r;
  logic [1:0]          wr_burst_r, bresp_r;
  logic                wr_slverr_r, wr_decerr_r, wr_dec_s;
  logic                aw_hs_s, w_hs_s, wr_last_s, wr_mismatch_s, mem_we_s;

  // ---------------- read channel ----------------
  rd_state_e           rd_state_r, rd_state_s;
  logic [ID_WIDTH-1:0] rd_id_r;
  logic [31:0]         rd_addr_r, rd_next_s, rd_mem_addr_s, rdata_r;
  logic [7:0]          rd_len_r, rd_cnt_r;
  logic [2:0]          rd_size_r;
  logic [1:0]          rd_burst_r, rresp_r;
  logic                rlast_r, rd_dec_s, ar_hs_s, r_hs_s, rd_load_s;

`ifdef AXI_MEM_DECERR_EN
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (MEM_AW + 2)) == 32'd0);
  endfunction
  assign wr_dec_s = ~in_range(wr_addr_r);
  assign rd_dec_s = ~in_range(rd_mem_addr_s);
`else
  assign wr_dec_s = 1'b0;
  assign rd_dec_s = 1'b0;
`endif

  assign aw_hs_s       = s_axi_awvalid & s_axi_awready;
  assign w_hs_s        = s_axi_wvalid & s_axi_wready;
  assign wr_last_s     = (wr_cnt_r == wr_len_r);
  assign wr_mismatch_s = (s_axi_wlast != wr_last_s);
  assign mem_we_s      = w_hs_s & ~wr_dec_s;

  axi_mem_addr_gen u_wr_addr_gen (
    .addr(wr_addr_r), .size(wr_size_r), .len(wr_len_r), .burst(wr_burst_r),
    .next_addr(wr_next_s)
  );

  // Write FSM state register.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) wr_state_r <= W_IDLE;
    else              wr_state_r <= wr_state_s;
  end

  // Write FSM next state: the beat counter, not wlast, ends the burst.
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      W_IDLE: if (s_axi_awvalid) wr_state_s = W_DATA; else wr_state_s = W_IDLE;
      W_DATA: if (s_axi_wvalid && wr_last_s) wr_state_s = W_RESP; else wr_state_s = W_DATA;
      W_RESP: if (s_axi_bready) wr_state_s = W_IDLE; else wr_state_s = W_RESP;
      default: wr_state_s = W_IDLE;
    endcase
  end

  // Write channel handshake outputs decoded from state.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (wr_state_r)
      W_IDLE:  s_axi_awready = 1'b1;
      W_DATA:  s_axi_wready  = 1'b1;
      W_RESP:  s_axi_bvalid  = 1'b1;
      default: s_axi_awready = 1'b0;
    endcase
  end

  // Write burst context: latch on AW, step per beat, fold errors into bresp.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      wr_id_r     <= '0;
      wr_addr_r   <= 32'd0;
      wr_len_r    <= 8'd0;
      wr_cnt_r    <= 8'd0;
      wr_size_r   <= 3'd0;
      wr_burst_r  <= 2'd0;
      wr_slverr_r <= 1'b0;
      wr_decerr_r <= 1'b0;
      bresp_r     <= RESP_OKAY;
    end else if (aw_hs_s) begin
      wr_id_r     <= s_axi_awid;
      wr_addr_r   <= s_axi_awaddr;
      wr_len_r    <= s_axi_awlen;
      wr_cnt_r    <= 8'd0;
      wr_size_r   <= s_axi_awsize;
      wr_burst_r  <= s_axi_awburst;
      wr_slverr_r <= 1'b0;
      wr_decerr_r <= 1'b0;
    end else if (w_hs_s) begin
      wr_addr_r   <= wr_next_s;
      wr_cnt_r    <= wr_cnt_r + 8'd1;
      wr_slverr_r <= wr_slverr_r | wr_mismatch_s;
      wr_decerr_r <= wr_decerr_r | wr_dec_s;
      if (wr_last_s) begin
        if (wr_decerr_r || wr_dec_s)             bresp_r <= RESP_DECERR;
        else if (wr_slverr_r || wr_mismatch_s)   bresp_r <= RESP_SLVERR;
        else                                     bresp_r <= RESP_OKAY;
      end
    end
  end

  assign s_axi_bid   = wr_id_r;
  assign s_axi_bresp = bresp_r;

  // Memory write port with per-byte enables; contents survive reset.
  always_ff @(posedge cpu_clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi_wstrb[i]) mem[word_idx(wr_addr_r)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  assign ar_hs_s   = s_axi_arvalid & s_axi_arready;
  assign r_hs_s    = s_axi_rvalid & s_axi_rready;
  assign rd_load_s = ar_hs_s | (r_hs_s & ~rlast_r);

  axi_mem_addr_gen u_rd_addr_gen (
    .addr(rd_addr_r), .size(rd_size_r), .len(rd_len_r), .burst(rd_burst_r),
    .next_addr(rd_next_s)
  );

  // Address presented to the read port: AR address when idle, otherwise the next beat.
  always_comb begin
    if (rd_state_r == R_IDLE) rd_mem_addr_s = s_axi_araddr;
    else                      rd_mem_addr_s = rd_next_s;
  end

  // Read FSM state register.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) rd_state_r <= R_IDLE;
    else              rd_state_r <= rd_state_s;
  end

  // Read FSM next state: leave only on the last-beat handshake.
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: if (s_axi_arvalid) rd_state_s = R_DATA; else rd_state_s = R_IDLE;
      R_DATA: if (s_axi_rready && rlast_r) rd_state_s = R_IDLE; else rd_state_s = R_DATA;
      default: rd_state_s = R_IDLE;
    endcase
  end

  // Read channel handshake outputs decoded from state.
  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (rd_state_r)
      R_IDLE:  s_axi_arready = 1'b1;
      R_DATA:  s_axi_rvalid  = 1'b1;
      default: s_axi_arready = 1'b0;
    endcase
  end

  // Read burst context: latch on AR, step the beat address on every non-last beat.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      rd_id_r    <= '0;
      rd_addr_r  <= 32'd0;
      rd_len_r   <= 8'd0;
      rd_cnt_r   <= 8'd0;
      rd_size_r  <= 3'd0;
      rd_burst_r <= 2'd0;
      rlast_r    <= 1'b0;
    end else if (ar_hs_s) begin
      rd_id_r    <= s_axi_arid;
      rd_addr_r  <= s_axi_araddr;
      rd_len_r   <= s_axi_arlen;
      rd_cnt_r   <= 8'd0;
      rd_size_r  <= s_axi_arsize;
      rd_burst_r <= s_axi_arburst;
      rlast_r    <= (s_axi_arlen == 8'd0);
    end else if (r_hs_s) begin
      if (rlast_r) begin
        rlast_r <= 1'b0;
      end else begin
        rd_addr_r <= rd_next_s;
        rd_cnt_r  <= rd_cnt_r + 8'd1;
        rlast_r   <= ((rd_cnt_r + 8'd1) == rd_len_r);
      end
    end
  end

  // Registered read port; loads only on a new beat so data holds under backpressure.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      rdata_r <= 32'd0;
      rresp_r <= RESP_OKAY;
    end else if (rd_load_s) begin
      if (rd_dec_s) begin
        rdata_r <= 32'd0;
        rresp_r <= RESP_DECERR;
      end else begin
        rdata_r <= mem[word_idx(rd_mem_addr_s)];
        rresp_r <= RESP_OKAY;
      end
    end
  end

  assign s_axi_rid   = rd_id_r;
  assign s_axi_rdata = rdata_r;
  assign s_axi_rresp = rresp_r;
  assign s_axi_rlast = rlast_r;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave.
module tb_axi_mem_slave;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset_n;
  logic [5:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] wd [16];
  logic [31:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [5:0]  rid_cap, bid_cap;
  logic [1:0]  bresp_cap;

  axi_mem_slave dut (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic note_timeout(input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL timeout_%s: no handshake within 50 cycles, required one", what);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [5:0] id, input logic [3:0] strb, input int last_beat);
    int n;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = 3'd2; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    if (n >= 50) note_timeout("aw");
    tick();
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wd[b]; s_axi_wstrb = strb;
      s_axi_wlast = (b == last_beat);
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      if (n >= 50) note_timeout("w");
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) note_timeout("b");
    bresp_cap = s_axi_bresp; bid_cap = s_axi_bid;
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [5:0] id);
    int n;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = 3'd2; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    if (n >= 50) note_timeout("ar");
    tick();
    s_axi_arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!s_axi_rvalid && n < 50) begin tick(); n++; end
      if (n >= 50) note_timeout("r");
      rd[b] = s_axi_rdata; rr[b] = s_axi_rresp; rl[b] = s_axi_rlast; rid_cap = s_axi_rid;
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    cpu_reset_n = 1'b0;
    s_axi_awid = 6'd0; s_axi_awaddr = 32'd0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'h0;
    s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arid = 6'd0; s_axi_araddr = 32'd0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({s_axi_awready, s_axi_arready} !== 2'b11) begin n_fail++;
      $display("FAIL reset_ready: got aw/ar=%b required 11", {s_axi_awready, s_axi_arready}); end
    n_cmp++; if ({s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_valids: got w/b/r/last=%b required 0000",
               {s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}); end
    n_cmp++; if ({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rdata} !== 48'd0) begin n_fail++;
      $display("FAIL reset_payload: got bid=%h bresp=%h rid=%h rresp=%h rdata=%h required all 0",
               s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp, s_axi_rdata); end
    cpu_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    tick();
    n_cmp++; if (s_axi_wready !== 1'b0) begin n_fail++;
      $display("FAIL early_w: got wready=%b required 0", s_axi_wready); end
    s_axi_awid = 6'h05; s_axi_awaddr = 32'h100; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    n_cmp++; if (s_axi_wready !== 1'b1) begin n_fail++;
      $display("FAIL single_wready_t1: got %b required 1", s_axi_wready); end
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    n_cmp++; if ({s_axi_bvalid, s_axi_bresp, s_axi_bid} !== {1'b1, 2'b00, 6'h05}) begin n_fail++;
      $display("FAIL single_b: got bvalid=%b bresp=%b bid=%h required 1/00/05",
               s_axi_bvalid, s_axi_bresp, s_axi_bid); end
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
    n_cmp++; if (s_axi_bvalid !== 1'b0) begin n_fail++;
      $display("FAIL single_b_drop: got bvalid=%b required 0", s_axi_bvalid); end
    s_axi_arid = 6'h09; s_axi_araddr = 32'h100; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    n_cmp++; if ({s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_rresp, s_axi_rdata} !==
                 {1'b1, 1'b1, 6'h09, 2'b00, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL single_r: got valid=%b last=%b rid=%h rresp=%b rdata=%h required 1/1/09/00/deadbeef",
               s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_rresp, s_axi_rdata); end
    s_axi_rready = 1'b1; tick(); s_axi_rready = 1'b0;
    n_cmp++; if (s_axi_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL single_r_drop: got rvalid=%b required 0", s_axi_rvalid); end
  endtask

  task automatic test_incr_backpressure();
    logic [31:0] exp_d [4];
    int e;
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    for (int i = 0; i < 4; i++) wd[i] = exp_d[i];
    do_write(32'h200, 8'd3, 2'b01, 6'h03, 4'hF, 3);
    n_cmp++; if ({bresp_cap, bid_cap} !== {2'b00, 6'h03}) begin n_fail++;
      $display("FAIL incr_b: got bresp=%b bid=%h required 00/03", bresp_cap, bid_cap); end
    s_axi_arid = 6'h2A; s_axi_araddr = 32'h200; s_axi_arlen = 8'd3; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    e = 0;
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if ({s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid} !==
                   {1'b1, exp_d[e], (e == 3), 6'h2A}) begin n_fail++;
        $display("FAIL incr_beat%0d_c%0d: got v=%b d=%h last=%b id=%h required 1/%h/%b/2a",
                 e, c, s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid, exp_d[e], (e == 3)); end
      s_axi_rready = (c % 2 == 1);
      tick();
      if (s_axi_rready) e++;
    end
    s_axi_rready = 1'b0;
    n_cmp++; if (s_axi_rvalid !== 1'b0) begin n_fail++;
      $display("FAIL incr_end: got rvalid=%b required 0", s_axi_rvalid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wd[i] = 32'hA000_0000 + 32'(i);
    do_write(32'h300, 8'd3, 2'b01, 6'h01, 4'hF, 3);
    do_read(32'h30C, 8'd3, 2'b10, 6'h11);
    n_cmp++; if ({rd[0], rd[1], rd[2], rd[3]} !== {32'hA000_0003, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002})
    begin n_fail++;
      $display("FAIL wrap_data: got %h %h %h %h required a0000003 a0000000 a0000001 a0000002",
               rd[0], rd[1], rd[2], rd[3]); end
    n_cmp++; if ({rl[0], rl[1], rl[2], rl[3], rr[0], rr[3]} !== {4'b0001, 4'b0000}) begin n_fail++;
      $display("FAIL wrap_last: got last=%b%b%b%b resp=%b/%b required 0001 00/00",
               rl[0], rl[1], rl[2], rl[3], rr[0], rr[3]); end
    do_read(32'h300, 8'd1, 2'b11, 6'h12);
    n_cmp++; if ({rd[0], rd[1]} !== {32'hA000_0000, 32'hA000_0001}) begin n_fail++;
      $display("FAIL reserved_burst: got %h %h required a0000000 a0000001", rd[0], rd[1]); end
  endtask

  task automatic test_strobe_fixed();
    wd[0] = 32'h1122_3344; do_write(32'h400, 8'd0, 2'b01, 6'h02, 4'hF, 0);
    wd[0] = 32'hAABB_CCDD; do_write(32'h400, 8'd0, 2'b01, 6'h02, 4'b0101, 0);
    do_read(32'h400, 8'd0, 2'b01, 6'h02);
    n_cmp++; if (rd[0] !== 32'h11BB_33DD) begin n_fail++;
      $display("FAIL strobe: got %h required 11bb33dd", rd[0]); end
    wd[0] = 32'h55; do_write(32'h408, 8'd0, 2'b01, 6'h02, 4'hF, 0);
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    do_write(32'h404, 8'd2, 2'b00, 6'h02, 4'hF, 2);
    do_read(32'h404, 8'd1, 2'b01, 6'h02);
    n_cmp++; if ({rd[0], rd[1]} !== {32'h3, 32'h55}) begin n_fail++;
      $display("FAIL fixed: got %h %h required 00000003 00000055", rd[0], rd[1]); end
  endtask

  task automatic test_wlast_mismatch();
    wd[0] = 32'hB0; wd[1] = 32'hB1;
    do_write(32'h500, 8'd1, 2'b01, 6'h0C, 4'hF, 0);
    n_cmp++; if ({bresp_cap, bid_cap} !== {2'b10, 6'h0C}) begin n_fail++;
      $display("FAIL wlast_early: got bresp=%b bid=%h required 10/0c", bresp_cap, bid_cap); end
    do_read(32'h500, 8'd1, 2'b01, 6'h0C);
    n_cmp++; if ({rd[0], rd[1]} !== {32'hB0, 32'hB1}) begin n_fail++;
      $display("FAIL wlast_two_beats: got %h %h required b0 b1", rd[0], rd[1]); end
    wd[0] = 32'hC0;
    do_write(32'h508, 8'd0, 2'b01, 6'h0D, 4'hF, -1);
    n_cmp++; if (bresp_cap !== 2'b10) begin n_fail++;
      $display("FAIL wlast_missing: got bresp=%b required 10", bresp_cap); end
    do_write(32'h50C, 8'd0, 2'b01, 6'h0E, 4'hF, 0);
    n_cmp++; if (bresp_cap !== 2'b00) begin n_fail++;
      $display("FAIL wlast_cleared: got bresp=%b required 00", bresp_cap); end
  endtask

  task automatic test_reset_mid_read();
    s_axi_arid = 6'h15; s_axi_araddr = 32'h200; s_axi_arlen = 8'd7; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    tick(); tick();
    s_axi_rready = 1'b0;
    n_cmp++; if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'h33}) begin n_fail++;
      $display("FAIL midread_beat2: got v=%b d=%h required 1/00000033", s_axi_rvalid, s_axi_rdata); end
    cpu_reset_n = 1'b0;
    #1;
    n_cmp++; if ({s_axi_rvalid, s_axi_arready} !== 2'b01) begin n_fail++;
      $display("FAIL midread_reset: got rvalid=%b arready=%b required 0/1", s_axi_rvalid, s_axi_arready); end
    tick();
    cpu_reset_n = 1'b1;
    tick();
    n_cmp++; if ({s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rdata} !== {3'b110, 32'd0}) begin n_fail++;
      $display("FAIL post_reset: got ar=%b aw=%b rv=%b d=%h required 1/1/0/0",
               s_axi_arready, s_axi_awready, s_axi_rvalid, s_axi_rdata); end
    do_read(32'h100, 8'd0, 2'b01, 6'h01);
    n_cmp++; if (rd[0] !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL mem_kept: got %h required deadbeef", rd[0]); end
  endtask

  task automatic test_concurrent();
    s_axi_awid = 6'h07; s_axi_awaddr = 32'h600; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b1;
    s_axi_arid = 6'h08; s_axi_araddr = 32'h200; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    n_cmp++; if ({s_axi_rvalid, s_axi_rdata, s_axi_wready} !== {1'b1, 32'h11, 1'b1}) begin n_fail++;
      $display("FAIL conc_start: got rv=%b d=%h wready=%b required 1/00000011/1",
               s_axi_rvalid, s_axi_rdata, s_axi_wready); end
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
    s_axi_rready = 1'b1;
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_rready = 1'b0;
    n_cmp++; if ({s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_rvalid} !== {1'b1, 6'h07, 2'b00, 1'b0}) begin n_fail++;
      $display("FAIL conc_end: got bv=%b bid=%h bresp=%b rv=%b required 1/07/00/0",
               s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_rvalid); end
    s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
    do_read(32'h600, 8'd0, 2'b01, 6'h08);
    n_cmp++; if (rd[0] !== 32'h77) begin n_fail++;
      $display("FAIL conc_data: got %h required 00000077", rd[0]); end
    wd[0] = 32'h1; do_write(32'h700, 8'd0, 2'b01, 6'h01, 4'hF, 0);
    s_axi_awaddr = 32'h700; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h2; s_axi_wlast = 1'b1;
    s_axi_araddr = 32'h700; s_axi_arvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    n_cmp++; if ({s_axi_rvalid, s_axi_rdata} !== {1'b1, 32'h1}) begin n_fail++;
      $display("FAIL read_first: got v=%b d=%h required 1/00000001", s_axi_rvalid, s_axi_rdata); end
    s_axi_rready = 1'b1; s_axi_bready = 1'b1; tick(); s_axi_rready = 1'b0; s_axi_bready = 1'b0;
    do_read(32'h700, 8'd0, 2'b01, 6'h01);
    n_cmp++; if (rd[0] !== 32'h2) begin n_fail++;
      $display("FAIL collision_after: got %h required 00000002", rd[0]); end
  endtask

  task automatic test_out_of_window();
    do_read(32'h0004_0100, 8'd0, 2'b01, 6'h3F);
`ifdef AXI_MEM_DECERR_EN
    n_cmp++; if ({rr[0], rd[0]} !== {2'b11, 32'd0}) begin n_fail++;
      $display("FAIL decerr_read: got rresp=%b rdata=%h required 11/0", rr[0], rd[0]); end
`else
    n_cmp++; if ({rr[0], rd[0]} !== {2'b00, 32'hDEAD_BEEF}) begin n_fail++;
      $display("FAIL alias_read: got rresp=%b rdata=%h required 00/deadbeef", rr[0], rd[0]); end
`endif
    n_cmp++; if (rid_cap !== 6'h3F) begin n_fail++;
      $display("FAIL oow_rid: got %h required 3f", rid_cap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_backpressure();
    test_wrap();
    test_strobe_fixed();
    test_wlast_mismatch();
    test_reset_mid_read();
    test_concurrent();
    test_out_of_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
